// File: rtl/load_ext_pipe.sv
// Load-data lane select and sign/zero extension for the MEM/WB boundary.
// Results are queued in a 2-entry FIFO so a WB stall does not drop loads.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_exc
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LH  = 3'd4;
  localparam logic [2:0] OP_LWU = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              exc;
  } entry_t;

  logic [31:0]       lane_w;
  logic [15:0]       lane_h;
  logic [7:0]        lane_b;
  logic [DATA_W-1:0] ext_data;
  logic              ext_exc;
  entry_t            ext_entry;

  entry_t     slot_q [2];
  logic [1:0] count_q;
  logic       rd_q;
  logic       wr_q;
  logic       push;
  logic       pop;

  // Shift the addressed byte down to bit 0; narrower lanes are slices of it.
  assign lane_w = 32'(in_data >> {in_off, 3'b000});
  assign lane_h = lane_w[15:0];
  assign lane_b = lane_w[7:0];

  always_comb begin
    ext_data = '0;
    ext_exc  = 1'b0;
    unique case (in_op)
      OP_LW: begin
        ext_data = DATA_W'(signed'(lane_w));
        ext_exc  = |in_off[1:0];
      end
      OP_LBU: begin
        ext_data = DATA_W'(lane_b);
      end
      OP_LB: begin
        ext_data = DATA_W'(signed'(lane_b));
      end
      OP_LHU: begin
        ext_data = DATA_W'(lane_h);
        ext_exc  = in_off[0];
      end
      OP_LH: begin
        ext_data = DATA_W'(signed'(lane_h));
        ext_exc  = in_off[0];
      end
      OP_LWU: begin
        ext_data = DATA_W'(lane_w);
        ext_exc  = |in_off[1:0];
      end
      OP_LD: begin
        if (DATA_W == 64) begin
          ext_data = in_data;
          ext_exc  = |in_off;
        end else begin
          ext_exc = 1'b1;
        end
      end
      default: begin
        ext_exc = 1'b1;
      end
    endcase
    if (ext_exc) begin
      ext_data = '0;
    end
  end

  assign ext_entry = '{data: ext_data, tag: in_tag, exc: ext_exc};

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot_q[rd_q].data;
  assign out_tag   = slot_q[rd_q].tag;
  assign out_exc   = slot_q[rd_q].exc;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
    end else if (flush) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      if (push) begin
        slot_q[wr_q] <= ext_entry;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench for load_ext_pipe: 32-bit and 64-bit instances,
// directed vectors with hand-computed results.
module tb_load_ext_pipe;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        flush32 = 0, v32 = 0, r32, ov32, ordy32 = 1, oe32;
  logic [2:0]  op32 = 0;
  logic [1:0]  off32 = 0;
  logic [31:0] d32 = 0, od32;
  logic [4:0]  tag32 = 0, ot32;

  logic        flush64 = 0, v64 = 0, r64, ov64, ordy64 = 1, oe64;
  logic [2:0]  op64 = 0;
  logic [2:0]  off64 = 0;
  logic [63:0] d64 = 0, od64;
  logic [4:0]  tag64 = 0, ot64;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int checks = 0;
  int errors = 0;

  load_ext_pipe #(.DATA_W(32), .TAG_W(5)) u32 (
    .clk(clk), .reset(reset), .flush(flush32),
    .in_valid(v32), .in_ready(r32), .in_op(op32), .in_off(off32),
    .in_data(d32), .in_tag(tag32),
    .out_valid(ov32), .out_ready(ordy32), .out_data(od32),
    .out_tag(ot32), .out_exc(oe32)
  );

  load_ext_pipe #(.DATA_W(64), .TAG_W(5)) u64 (
    .clk(clk), .reset(reset), .flush(flush64),
    .in_valid(v64), .in_ready(r64), .in_op(op64), .in_off(off64),
    .in_data(d64), .in_tag(tag64),
    .out_valid(ov64), .out_ready(ordy64), .out_data(od64),
    .out_tag(ot64), .out_exc(oe64)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever a DUT hands over its head entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (ov32 && ordy32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected32 got tag %0d want none", ot32);
        end else begin
          e32 = q32.pop_front();
          chk("data32", {32'd0, od32}, e32.d);
          chk("tag32", {59'd0, ot32}, {59'd0, e32.t});
          chk("exc32", {63'd0, oe32}, {63'd0, e32.e});
        end
      end
      if (ov64 && ordy64) begin
        if (q64.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected64 got tag %0d want none", ot64);
        end else begin
          e64 = q64.pop_front();
          chk("data64", od64, e64.d);
          chk("tag64", {59'd0, ot64}, {59'd0, e64.t});
          chk("exc64", {63'd0, oe64}, {63'd0, e64.e});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic drive(input bit w, input logic [2:0] op,
                       input logic [2:0] off, input logic [63:0] data,
                       input logic [4:0] tag, input logic [63:0] ed,
                       input bit ee);
    bit ok;
    exp_t x;
    x.d = ed;
    x.t = tag;
    x.e = ee;
    if (w) begin
      v64 = 1; op64 = op; off64 = off; d64 = data; tag64 = tag;
    end else begin
      v32 = 1; op32 = op; off32 = off[1:0]; d32 = data[31:0]; tag32 = tag;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w ? r64 : r32) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got in_ready 0 want 1 tag %0d", tag);
    end else begin
      @(posedge clk);
      if (w) q64.push_back(x);
      else q32.push_back(x);
    end
    #1;
    v32 = 0;
    v64 = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(posedge clk);
    end
    #1;
    checks++;
    if (q32.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0",
               q32.size(), q64.size());
    end
  endtask

  exp_t sx;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", {63'd0, ov32}, 64'd0);
    chk("rst_data32", {32'd0, od32}, 64'd0);
    chk("rst_tag32", {59'd0, ot32}, 64'd0);
    chk("rst_exc32", {63'd0, oe32}, 64'd0);
    chk("rst_ready32", {63'd0, r32}, 64'd1);
    chk("rst_valid64", {63'd0, ov64}, 64'd0);
    chk("rst_ready64", {63'd0, r64}, 64'd1);
    reset = 0;
    @(posedge clk);
    #1;

    // Byte lanes, each visible one cycle after its push
    drive(0, 3'd2, 3'd3, 64'h80FF_7F01, 5'd1, 64'hFFFF_FF80, 0);
    @(negedge clk); chk("lat_lb3", {63'd0, ov32}, 64'd1);
    @(posedge clk); #1;
    drive(0, 3'd1, 3'd3, 64'h80FF_7F01, 5'd2, 64'h0000_0080, 0);
    @(negedge clk); chk("lat_lbu3", {63'd0, ov32}, 64'd1);
    @(posedge clk); #1;
    drive(0, 3'd2, 3'd1, 64'h80FF_7F01, 5'd3, 64'h0000_007F, 0);
    drive(0, 3'd2, 3'd0, 64'h80FF_7F01, 5'd4, 64'h0000_0001, 0);
    // Halves and faults
    drive(0, 3'd4, 3'd2, 64'h8001_1234, 5'd5, 64'hFFFF_8001, 0);
    drive(0, 3'd3, 3'd2, 64'h8001_1234, 5'd6, 64'h0000_8001, 0);
    drive(0, 3'd4, 3'd1, 64'h8001_1234, 5'd7, 64'd0, 1);
    drive(0, 3'd0, 3'd2, 64'h8001_1234, 5'd8, 64'd0, 1);
    drive(0, 3'd7, 3'd0, 64'h8001_1234, 5'd9, 64'd0, 1);
    drive(0, 3'd6, 3'd0, 64'h8001_1234, 5'd10, 64'd0, 1);
    drive(0, 3'd5, 3'd0, 64'h8001_1234, 5'd11, 64'h8001_1234, 0);
    wait_drain();

    // Back-pressure
    ordy32 = 0;
    drive(0, 3'd1, 3'd0, 64'h0000_00AA, 5'd3, 64'h0000_00AA, 0);
    drive(0, 3'd1, 3'd1, 64'h0000_BB00, 5'd4, 64'h0000_00BB, 0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready", {63'd0, r32}, 64'd0);
      chk("bp_valid", {63'd0, ov32}, 64'd1);
      chk("bp_head", {59'd0, ot32}, 64'd3);
    end
    @(posedge clk); #1;
    ordy32 = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_back", {63'd0, r32}, 64'd1);
    chk("bp_second", {59'd0, ot32}, 64'd4);
    @(posedge clk); #1;
    wait_drain();

    // Streaming
    ordy32 = 1;
    for (int i = 0; i < 8; i++) begin
      sx.d = 64'h8000_0000 | (64'(i) * 64'h0101_0101);
      sx.t = 5'(i + 12);
      sx.e = 0;
      v32 = 1; op32 = 3'd0; off32 = 2'd0; d32 = sx.d[31:0]; tag32 = sx.t;
      @(negedge clk);
      chk("stream_ready", {63'd0, r32}, 64'd1);
      if (i > 0) chk("stream_gap", {63'd0, ov32}, 64'd1);
      @(posedge clk);
      q32.push_back(sx);
      #1;
    end
    v32 = 0;
    wait_drain();

    // Flush with two buffered plus one incoming
    ordy32 = 0;
    drive(0, 3'd1, 3'd0, 64'h11, 5'd20, 64'h11, 0);
    drive(0, 3'd1, 3'd0, 64'h22, 5'd21, 64'h22, 0);
    v32 = 1; op32 = 3'd1; off32 = 2'd0; d32 = 32'h33; tag32 = 5'd22;
    flush32 = 1;
    @(posedge clk); #1;
    flush32 = 0;
    v32 = 0;
    q32.delete();
    @(negedge clk);
    chk("flush_valid", {63'd0, ov32}, 64'd0);
    chk("flush_ready", {63'd0, r32}, 64'd1);
    @(posedge clk); #1;
    ordy32 = 1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_empty", {63'd0, ov32}, 64'd0);
    end
    @(posedge clk); #1;
    drive(0, 3'd1, 3'd0, 64'h44, 5'd23, 64'h44, 0);
    wait_drain();

    // 64-bit lanes
    drive(1, 3'd0, 3'd0, 64'h8000_0000_FFFF_FFFE, 5'd1,
          64'hFFFF_FFFF_FFFF_FFFE, 0);
    drive(1, 3'd5, 3'd0, 64'h8000_0000_FFFF_FFFE, 5'd2,
          64'h0000_0000_FFFF_FFFE, 0);
    drive(1, 3'd0, 3'd4, 64'h8000_0000_FFFF_FFFE, 5'd3,
          64'hFFFF_FFFF_8000_0000, 0);
    drive(1, 3'd6, 3'd0, 64'h8000_0000_FFFF_FFFE, 5'd4,
          64'h8000_0000_FFFF_FFFE, 0);
    drive(1, 3'd6, 3'd4, 64'h8000_0000_FFFF_FFFE, 5'd5, 64'd0, 1);
    drive(1, 3'd2, 3'd7, 64'h8000_0000_FFFF_FFFE, 5'd6,
          64'hFFFF_FFFF_FFFF_FF80, 0);
    wait_drain();

    // Asynchronous reset with entries held
    ordy32 = 0;
    ordy64 = 0;
    drive(0, 3'd2, 3'd3, 64'h80FF_7F01, 5'd11, 64'hFFFF_FF80, 0);
    drive(1, 3'd0, 3'd0, 64'h8000_0000_FFFF_FFFE, 5'd12,
          64'hFFFF_FFFF_FFFF_FFFE, 0);
    #3 reset = 1;
    #1;
    chk("arst_valid32", {63'd0, ov32}, 64'd0);
    chk("arst_data32", {32'd0, od32}, 64'd0);
    chk("arst_tag32", {59'd0, ot32}, 64'd0);
    chk("arst_exc32", {63'd0, oe32}, 64'd0);
    chk("arst_ready32", {63'd0, r32}, 64'd1);
    chk("arst_valid64", {63'd0, ov64}, 64'd0);
    chk("arst_data64", od64, 64'd0);
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    reset = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
